// File: rtl/inst_encoder.sv
// Packs RV32I instruction fields plus immediate into a 32-bit word, queued with a byte address.
// Optional ENC_ERR_DROP_EN: drop unrepresentable instructions and flag them on err_sticky.
module inst_encoder #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
`ifdef ENC_ERR_DROP_EN
  ,
  output logic              err_sticky
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]       inst;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sticky_q, sticky_d;

  logic [31:0] enc_inst;
  logic        enc_err;
  logic        push, enq, deq;
  entry_t      head;

  // Immediate fits when the bits above the field's top bit are pure sign extension.
  logic fits_11, fits_12, fits_20;
  assign fits_11 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_12 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits_20 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    enc_inst = '0;
    enc_err  = 1'b0;
    case (in_fmt)
      3'b000: begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = ~fits_11;
      end
      3'b001: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err  = ~fits_11;
      end
      3'b010: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                    in_imm[11], in_opcode};
        enc_err  = ~fits_12 | in_imm[0];
      end
      3'b011: begin
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
        enc_err  = |in_imm[11:0];
      end
      3'b100: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err  = ~fits_20 | in_imm[0];
      end
      default: begin
        enc_inst = '0;
        enc_err  = 1'b1;
      end
    endcase
  end

  assign in_ready  = (count_q != CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~clr;
`ifdef ENC_ERR_DROP_EN
  assign enq       = push & ~enc_err;
`else
  assign enq       = push;
`endif
  assign deq       = out_valid & out_ready & ~clr;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    sticky_d = sticky_q;
    if (clr) begin
      wptr_d   = '0;
      rptr_d   = '0;
      count_d  = '0;
      addr_d   = BASE_ADDR;
      sticky_d = 1'b0;
    end else begin
      if (enq) begin
        wptr_d = wptr_q + 1'b1;
        addr_d = addr_q + ADDR_W'(4);
      end
      if (deq) rptr_d = rptr_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      sticky_d = sticky_q | (push & enc_err);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      sticky_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wptr_q] <= '{inst: enc_inst, addr: addr_q, err: enc_err};
  end

  assign head     = mem_q[rptr_q];
  assign out_inst = out_valid ? head.inst : '0;
  assign out_addr = out_valid ? head.addr : '0;
`ifdef ENC_ERR_DROP_EN
  assign out_err    = 1'b0;
  assign err_sticky = sticky_q;
`else
  assign out_err  = out_valid & head.err;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: a reference model queues expected words; a monitor checks the head.
module tb_inst_encoder;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_imm = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_inst, out_addr;
  logic        in_ready2, out_valid2, out_err2;
  logic [31:0] out_inst2;
  logic [3:0]  out_addr2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(32), .BASE_ADDR(32'd0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err)
  );

  // Narrow address counter seeded near wrap, fed the same stream.
  inst_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm), .out_valid(out_valid2), .out_ready(out_ready),
    .out_inst(out_inst2), .out_addr(out_addr2), .out_err(out_err2)
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [31:0] addr;
    logic [3:0]  addr2;
    logic        lit_en;
    logic [31:0] lit;
    logic        lit_err;
  } exp_t;

  exp_t        sb[$];
  longint      model_addr;
  longint      model_addr2;
  logic        lit_en = 1'b0;
  logic [31:0] lit = '0;
  logic        lit_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Reference encoder from the format rules: returns {err, inst}.
  function automatic logic [32:0] ref_enc(input logic [2:0] fmt, input logic [6:0] op,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3,
                                          input logic [31:0] imm);
    longint unsigned u, w, base;
    longint          s;
    logic            ok;
    u    = imm;
    s    = longint'($signed(imm));
    base = longint'(op) | (longint'(f3) << 12) | (longint'(rs1) << 15);
    w    = 0;
    ok   = 1'b0;
    case (fmt)
      3'd0: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = base | (longint'(rd) << 7) | ((u % 4096) << 20);
      end
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = base | (longint'(rs2) << 20) | ((u % 32) << 7) | (((u / 32) % 128) << 25);
      end
      3'd2: begin
        ok = (s >= -4096) && (s <= 4095) && (u % 2 == 0);
        w  = base | (longint'(rs2) << 20) | (((u / 2) % 16) << 8) | (((u / 2048) % 2) << 7)
           | (((u / 32) % 64) << 25) | (((u / 4096) % 2) << 31);
      end
      3'd3: begin
        ok = (u % 4096 == 0);
        w  = longint'(op) | (longint'(rd) << 7) | (u - (u % 4096));
      end
      3'd4: begin
        ok = (s >= -(64'sd1 << 20)) && (s < (64'sd1 << 20)) && (u % 2 == 0);
        w  = longint'(op) | (longint'(rd) << 7) | (((u / 4096) % 256) << 12)
           | (((u / 2048) % 2) << 20) | (((u / 2) % 1024) << 21) | (((u >> 20) % 2) << 31);
      end
      default: begin
        ok = 1'b0;
        w  = 0;
      end
    endcase
    return {~ok, w[31:0]};
  endfunction

  // Reference FIFO: occupancy and ordering kept purely as a queue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      model_addr  = 0;
      model_addr2 = 12;
    end else if (clr) begin
      sb.delete();
      model_addr  = 0;
      model_addr2 = 12;
    end else begin
      int n;
      n = sb.size();
      if (n > 0 && out_ready) void'(sb.pop_front());
      if (in_valid && n < DEPTH) begin
        exp_t        e;
        logic [32:0] r;
        r         = ref_enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
        e.inst    = r[31:0];
        e.err     = r[32];
        e.addr    = model_addr[31:0];
        e.addr2   = model_addr2[3:0];
        e.lit_en  = lit_en;
        e.lit     = lit;
        e.lit_err = lit_err;
        sb.push_back(e);
        model_addr  = (model_addr + 4) % (64'd1 << 32);
        model_addr2 = (model_addr2 + 4) % 16;
      end
    end
  end

  // Monitor: compares the head and handshakes away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, sb.size() < DEPTH});
      check("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      check("out_valid2", {31'd0, out_valid2}, {31'd0, sb.size() != 0});
      if (sb.size() != 0 && out_valid) begin
        check("out_inst", out_inst, sb[0].inst);
        check("out_err", {31'd0, out_err}, {31'd0, sb[0].err});
        check("out_addr", out_addr, sb[0].addr);
        check("out_addr_wrap", {28'd0, out_addr2}, {28'd0, sb[0].addr2});
        if (sb[0].lit_en) begin
          check("plan_inst", out_inst, sb[0].lit);
          check("plan_err", {31'd0, out_err}, {31'd0, sb[0].lit_err});
        end
      end
    end
  end

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_imm = imm;
  endtask

  // Holds in_valid until the word is accepted, bounded.
  task automatic push(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [31:0] imm, input logic le, input logic [31:0] lv,
                      input logic lerr);
    int budget;
    @(negedge clk);
    drive(fmt, op, rd, rs1, rs2, f3, imm);
    lit_en = le; lit = lv; lit_err = lerr;
    in_valid = 1'b1;
    budget = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: in_ready=%0b, expected 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    lit_en   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 5))
      0: return 32'($signed($urandom_range(0, 8191)) - 4096);
      1: return $urandom();
      2: return $urandom() & 32'hFFFF_F000;
      3: return 32'($signed($urandom_range(0, 32'h3F_FFFF)) - 32'sh20_0000);
      4: begin
        logic [31:0] edges [8];
        edges = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF,
                  32'd4094, 32'hFFFF_F000, 32'h000F_FFFE, 32'hFFF0_0000};
        return edges[$urandom_range(0, 7)];
      end
      default: return 32'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed encodings
    out_ready = 1'b1;
    push(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1, 32'h0050_0093, 1'b0);
    push(3'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8, 1'b1, 32'h0020_A423, 1'b0);
    push(3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd8, 1'b1, 32'hFE00_0CE3, 1'b0);
    push(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800, 1'b1, 32'h0010_00EF, 1'b0);
    push(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h801, 1'b0, 32'd0, 1'b0);
    push(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 1'b0, 32'd0, 1'b0);
    push(3'd7, 7'b0010011, 5'd3, 5'd4, 5'd5, 3'd1, 32'd1, 1'b1, 32'd0, 1'b1);
    idle(3);

    // Fill to full with consumer stalled, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(3'd3, 7'b0110111, 5'(i), 5'd0, 5'd0, 3'd0, 32'(i) << 12, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    drive(3'd0, 7'b0010011, 5'd9, 5'd9, 5'd0, 3'd0, 32'd99);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    push(3'd0, 7'b0010011, 5'd9, 5'd9, 5'd0, 3'd0, 32'd99, 1'b0, 32'd0, 1'b0);
    idle(6);

    // Flush with a concurrent push
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(3'd0, 7'b0010011, 5'(i), 5'd1, 5'd0, 3'd0, 32'(i), 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    push(3'd0, 7'b0010011, 5'd7, 5'd1, 5'd0, 3'd0, 32'd7, 1'b0, 32'd0, 1'b0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive(3'($urandom_range(0, 9) > 8 ? $urandom_range(5, 7) : $urandom_range(0, 4)),
            7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), rand_imm());
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 40) == 0);
    end
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    push(3'd0, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 32'd1, 1'b0, 32'd0, 1'b0);
    push(3'd0, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 32'd2, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_out_valid2", {31'd0, out_valid2}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    push(3'd3, 7'b0110111, 5'd2, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 1'b1, 32'h1234_5137, 1'b0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
